// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared types and constants for the program loader.
//   state_e   : loader FSM states
//   ACK_*_DEF : default acknowledge bytes sent to the UART TX
//   words_of  : RAM capacity in 32-bit words for a given byte-address width
package prog_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LEN  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int         MEM_DEF     = 19;
    localparam logic [7:0] ACK_OK_DEF  = 8'hAA;
    localparam logic [7:0] ACK_ERR_DEF = 8'hEE;

    // Capacity in words; the RAM is word addressed with MEM-2 address bits.
    function automatic logic [31:0] words_of(input int mem);
        return 32'd1 << (mem - 2);
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if: bundles the loader's UART-side and RAM-side signals.
//   start/rx_data/rx_valid    : control pulse and byte stream into the loader
//   we/addr/din               : RAM write port driven by the loader
//   busy/done/err             : status toward the core
//   ack_data/ack_valid        : acknowledge byte toward the UART TX
// master = the loader, slave = its environment (UART, RAM, core).
interface prog_loader_if #(
    parameter int MEM = 19
);
    logic            start;
    logic [7:0]      rx_data;
    logic            rx_valid;
    logic            we;
    logic [MEM-3:0]  addr;
    logic [31:0]     din;
    logic            busy;
    logic            done;
    logic            err;
    logic [7:0]      ack_data;
    logic            ack_valid;

    modport master (
        input  start, rx_data, rx_valid,
        output we, addr, din, busy, done, err, ack_data, ack_valid
    );

    modport slave (
        output start, rx_data, rx_valid,
        input  we, addr, din, busy, done, err, ack_data, ack_valid
    );
endinterface

// File: rtl/prog_loader_word_assembler.sv
// prog_loader_word_assembler: collects four bytes into a big-endian word.
//   clk, rst        : clock, async active-high reset
//   clr_i           : drop any partial word (start of a new load)
//   en_i            : byte strobe, already qualified by the loader state
//   byte_i          : incoming byte
//   word_valid_o    : high in the cycle the 4th byte arrives (combinational)
//   word_o          : assembled word, valid with word_valid_o
// Only the first three bytes are stored; the 4th is merged combinationally
// so the loader can register the word on the same edge it arrives.
module prog_loader_word_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);
    logic [1:0]  cnt_q,   cnt_d;
    logic [23:0] shreg_q, shreg_d;

    always_comb begin
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        if (clr_i) begin
            cnt_d   = 2'd0;
            shreg_d = 24'd0;
        end else if (en_i) begin
            cnt_d   = cnt_q + 2'd1;
            shreg_d = {shreg_q[15:0], byte_i};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= 2'd0;
            shreg_q <= 24'd0;
        end else begin
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
        end
    end

    assign word_valid_o = en_i && (cnt_q == 2'd3);
    assign word_o       = {shreg_q, byte_i};
endmodule

// File: rtl/prog_loader.sv
// prog_loader: writes a UART byte stream into the word-addressed RAM.
//   clk, rst : clock, async active-high reset
//   bus      : prog_loader_if.master (start, rx byte stream, RAM write port,
//              busy/done/err status, acknowledge byte to UART TX)
// Stream: 4-byte big-endian word count N, then N big-endian words written
// to addresses 0..N-1. One ack byte is sent when the load finishes or is
// rejected because N exceeds the RAM capacity.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int         MEM     = MEM_DEF,
    parameter logic [7:0] ACK_OK  = ACK_OK_DEF,
    parameter logic [7:0] ACK_ERR = ACK_ERR_DEF
) (
    input  logic          clk,
    input  logic          rst,
    prog_loader_if.master bus
);
    localparam logic [31:0]  WORDS = words_of(MEM);
    localparam logic [MEM-2:0] WONE = {{(MEM-2){1'b0}}, 1'b1};

    state_e          state_q;
    logic [31:0]     n_q;
    logic            hdr_q;     // header word captured, decision pending
    logic [MEM-2:0]  wcnt_q;    // words issued so far; one bit wider than addr
    logic            we_q;
    logic [MEM-3:0]  addr_q;
    logic [31:0]     din_q;
    logic            done_q;
    logic            err_q;
    logic            ack_valid_q;
    logic [7:0]      ack_data_q;

    logic            asm_clr;
    logic            asm_en;
    logic            word_valid;
    logic [31:0]     word;
    logic            armed;
    logic            issued_all;

    // Bytes only count while loading; a byte alongside start is dropped
    // because the state is still IDLE/DONE in that cycle.
    assign armed   = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign asm_clr = armed && bus.start;
    assign asm_en  = bus.rx_valid && ((state_q == ST_LEN) || (state_q == ST_DATA));

    assign issued_all = ({{(32-(MEM-1)){1'b0}}, wcnt_q} >= n_q);

    prog_loader_word_assembler u_asm (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (asm_clr),
        .en_i         (asm_en),
        .byte_i       (bus.rx_data),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            n_q         <= 32'd0;
            hdr_q       <= 1'b0;
            wcnt_q      <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            din_q       <= 32'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ack_valid_q <= 1'b0;
            ack_data_q  <= 8'd0;
        end else begin
            we_q        <= 1'b0;
            ack_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        state_q <= ST_LEN;
                        n_q     <= 32'd0;
                        hdr_q   <= 1'b0;
                        wcnt_q  <= '0;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                    end
                end
                ST_LEN: begin
                    // The length is judged one cycle after it arrives so an
                    // empty or rejected load reports done with the same
                    // two-cycle latency as the last data word.
                    if (hdr_q) begin
                        hdr_q <= 1'b0;
                        if (n_q == 32'd0) begin
                            state_q     <= ST_DONE;
                            done_q      <= 1'b1;
                            ack_valid_q <= 1'b1;
                            ack_data_q  <= ACK_OK;
                        end else if (n_q > WORDS) begin
                            state_q     <= ST_DONE;
                            done_q      <= 1'b1;
                            err_q       <= 1'b1;
                            ack_valid_q <= 1'b1;
                            ack_data_q  <= ACK_ERR;
                        end else begin
                            state_q <= ST_DATA;
                        end
                    end else if (word_valid) begin
                        n_q   <= word;
                        hdr_q <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (word_valid && !issued_all) begin
                        we_q   <= 1'b1;
                        addr_q <= wcnt_q[MEM-3:0];
                        din_q  <= word;
                        wcnt_q <= wcnt_q + WONE;
                    end
                    // wcnt_q already counts the word being written this cycle.
                    if (we_q && issued_all) begin
                        state_q     <= ST_DONE;
                        done_q      <= 1'b1;
                        ack_valid_q <= 1'b1;
                        ack_data_q  <= ACK_OK;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy      = (state_q == ST_LEN) || (state_q == ST_DATA);
    assign bus.we        = we_q;
    assign bus.addr      = addr_q;
    assign bus.din       = din_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.ack_valid = ack_valid_q;
    assign bus.ack_data  = ack_data_q;
endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;
    localparam int MEM   = 6;
    localparam int WORDS = 1 << (MEM - 2);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prog_loader_if #(.MEM(MEM)) bus();

    prog_loader #(.MEM(MEM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // observation side: RAM model and event log filled from the DUT outputs
    int          cyc = 0;
    logic [63:0] wq[$];
    logic [31:0] ram [0:WORDS-1];
    int          ack_cnt, consec, last_we_cyc, ack_cyc;
    logic [7:0]  ack_byte;
    logic        we_prev;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.we) begin
                wq.push_back({32'(bus.addr), bus.din});
                ram[bus.addr] = bus.din;
                last_we_cyc = cyc;
                if (we_prev) consec++;
            end
            we_prev = bus.we;
            if (bus.ack_valid) begin
                ack_cnt++;
                ack_byte = bus.ack_data;
                ack_cyc  = cyc;
            end
        end
    end

    // stimulus
    logic [31:0] wbuf [0:31];
    int          last_cyc;

    task automatic cyc_drive(input logic s, input logic v, input logic [7:0] d);
        bus.start    = s;
        bus.rx_valid = v;
        bus.rx_data  = d;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input logic s);
        repeat (gap) cyc_drive(1'b0, 1'b0, 8'h00);
        last_cyc = cyc;
        cyc_drive(s, 1'b1, b);
    endtask

    task automatic clear_log();
        wq.delete();
        ack_cnt = 0; consec = 0; we_prev = 1'b0; last_we_cyc = -1; ack_cyc = -1;
        ack_byte = 8'h00;
        for (int k = 0; k < WORDS; k++) ram[k] = 32'hx;
    endtask

    // Full load of n words from wbuf; expected results come from the stream rules.
    task automatic run_load(input int n, input int gapmax, input bit noise);
        int         exp_n;
        logic       exp_err;
        logic [7:0] exp_ack;
        logic [31:0] hdr;
        clear_log();
        exp_err = (n > WORDS);
        exp_ack = exp_err ? 8'hEE : 8'hAA;
        exp_n   = exp_err ? 0 : n;
        hdr     = 32'(n);
        cyc_drive(1'b1, 1'b1, 8'($urandom));   // byte with start must be dropped
        chk("busy_after_start", 64'(bus.busy), 64'd1);
        for (int i = 0; i < 4; i++)
            send_byte(hdr[31-8*i -: 8], $urandom_range(0, gapmax), 1'b0);
        for (int k = 0; k < exp_n; k++)
            for (int b = 0; b < 4; b++)
                send_byte(wbuf[k][31-8*b -: 8], $urandom_range(0, gapmax),
                          noise && ($urandom_range(0, 3) == 0));
        for (int i = 0; i < 20 && !bus.done; i++) cyc_drive(1'b0, 1'b0, 8'h00);
        chk("done", 64'(bus.done), 64'd1);
        repeat (3) cyc_drive(1'b0, 1'b1, 8'($urandom));   // ignored in DONE
        chk("ack_cnt", 64'(ack_cnt), 64'd1);
        chk("ack_data", 64'(ack_byte), 64'(exp_ack));
        chk("ack_lat", 64'(ack_cyc - last_cyc), 64'd2);
        chk("err", 64'(bus.err), 64'(exp_err));
        chk("busy_done", 64'(bus.busy), 64'd0);
        chk("n_writes", 64'(wq.size()), 64'(exp_n));
        chk("we_b2b", 64'(consec), 64'd0);
        if (exp_n > 0) chk("we_lat", 64'(last_we_cyc - last_cyc), 64'd1);
        for (int k = 0; k < exp_n && k < wq.size(); k++) begin
            chk("wr_addr", {32'd0, wq[k][63:32]}, 64'(k));
            chk("wr_data", {32'd0, wq[k][31:0]}, {32'd0, wbuf[k]});
            chk("ram_rd", {32'd0, ram[k]}, {32'd0, wbuf[k]});
        end
    endtask

    task automatic fill_rand(input int n);
        for (int k = 0; k < n && k < 32; k++) wbuf[k] = $urandom;
    endtask

    initial begin
        int n;
        bus.start = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
        clear_log();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", {bus.we, 32'(bus.addr), bus.din, bus.busy, bus.done, bus.err,
                           bus.ack_valid, bus.ack_data} & 64'hffff_ffff_ffff_ffff, 64'd0);
        rst = 1'b0;
        repeat (3) cyc_drive(1'b0, 1'b1, 8'h55);   // ignored in IDLE
        chk("idle_strays", 64'(wq.size() + bus.busy + bus.done), 64'd0);

        wbuf[0] = 32'hDEADBEEF; wbuf[1] = 32'h01234567;
        run_load(2, 1, 1'b0);
        run_load(0, 1, 1'b0);
        run_load(WORDS + 1, 0, 1'b0);
        wbuf[0] = $urandom;
        run_load(1, 0, 1'b0);
        fill_rand(WORDS);
        run_load(WORDS, 0, 1'b1);
        fill_rand(3);
        run_load(3, 0, 1'b1);

        // reset in the middle of a 4-word load
        clear_log();
        fill_rand(4);
        cyc_drive(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) send_byte((i == 3) ? 8'd4 : 8'd0, 0, 1'b0);
        for (int b = 0; b < 6; b++) send_byte(wbuf[b/4][31-8*(b%4) -: 8], 0, 1'b0);
        cyc_drive(1'b0, 1'b0, 8'h00);
        chk("mid_writes", 64'(wq.size()), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_outs", {bus.we, 32'(bus.addr), bus.din, bus.busy, bus.done, bus.err,
                               bus.ack_valid, bus.ack_data} & 64'hffff_ffff_ffff_ffff, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        cyc_drive(1'b0, 1'b1, 8'hA5);
        fill_rand(4);
        run_load(4, 1, 1'b0);

        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(0, WORDS + 2);
            fill_rand(n);
            run_load(n, $urandom_range(0, 2), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
